multiport_regfile: RTL and testbench

Parametrised register file that generalises the fixed 32×32, dual-write-port register file to configurable width and depth. It adds two registered read ports with write-through, per-entry valid tracking, an optional hardwired-zero entry 0, and a saturating write-collision counter. It sits in the datapath between the decode/writeback stages and the operand-fetch logic.

---
 rtl/multiport_regfile.sv | 78 +++++++
 tb/tb_multiport_regfile.sv | 136 +++++++++++++
 2 files changed

// File: rtl/multiport_regfile.sv
// multiport_regfile: parametrised dual-write, dual-read register file with write-through reads,
// per-entry valid bits, optional hardwired-zero entry 0 and a saturating write-collision counter.
module multiport_regfile #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter bit ZERO_REG = 1'b0,
    parameter int CNT_W = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             write1,
    input  logic [WIDTH-1:0] write_data1,
    input  logic [AW-1:0]    write_index1,
    input  logic             write2,
    input  logic [WIDTH-1:0] write_data2,
    input  logic [AW-1:0]    write_index2,
    input  logic [AW-1:0]    read_index1,
    output logic [WIDTH-1:0] read_value1,
    output logic             read_valid1,
    input  logic [AW-1:0]    read_index2,
    output logic [WIDTH-1:0] read_value2,
    output logic             read_valid2,
    output logic [CNT_W-1:0] collision_count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic ok1, ok2, w1, w2, coll;

    function automatic logic in_range(input logic [AW-1:0] r);
        return {1'b0, r} < (AW+1)'(DEPTH);
    endfunction

    function automatic logic writable(input logic [AW-1:0] r);
        return in_range(r) && !(ZERO_REG && r == '0);
    endfunction

    // {valid, value} of entry r as it stands after this edge's writes
    function automatic logic [WIDTH:0] peek(input logic [AW-1:0] r);
        return !in_range(r) ? '0 :
               (ZERO_REG && r == '0) ? {1'b1, {WIDTH{1'b0}}} :
               (w2 && r == write_index2) ? {1'b1, write_data2} :
               (w1 && r == write_index1) ? {1'b1, write_data1} :
               {vld[r], mem[r]};
    endfunction

    always_comb begin
        ok1 = write1 && writable(write_index1);
        ok2 = write2 && writable(write_index2);
        coll = ok1 && ok2 && write_index1 == write_index2;
        w1 = ok1 && !coll;
        w2 = ok2;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            vld <= '0;
            read_value1 <= '0;
            read_value2 <= '0;
            read_valid1 <= ZERO_REG && read_index1 == '0;
            read_valid2 <= ZERO_REG && read_index2 == '0;
            collision_count <= '0;
        end else begin
            if (w1) begin
                mem[write_index1] <= write_data1;
                vld[write_index1] <= 1'b1;
            end
            if (w2) begin
                mem[write_index2] <= write_data2;
                vld[write_index2] <= 1'b1;
            end
            {read_valid1, read_value1} <= peek(read_index1);
            {read_valid2, read_value2} <= peek(read_index2);
            collision_count <= collision_count + CNT_W'(coll && !(&collision_count));
        end
    end
endmodule

// File: tb/tb_multiport_regfile.sv
// tb_multiport_regfile: drives two regfile instances (32 entries plain, 20 entries with zero entry)
// from shared inputs and compares them against an array-based reference model.
module tb_multiport_regfile;
    logic clock = 1'b0;
    logic clear, write1, write2;
    logic [31:0] write_data1, write_data2;
    logic [4:0] write_index1, write_index2, read_index1, read_index2;
    logic [31:0] rv1 [2];
    logic [31:0] rv2 [2];
    logic rl1 [2];
    logic rl2 [2];
    logic [7:0] cc [2];
    int checks = 0, errors = 0;

    int depth [2] = '{32, 20};
    bit zr [2] = '{1'b0, 1'b1};
    logic [31:0] m_mem [2][32];
    bit m_vld [2][32];
    int m_cnt [2];

    always #5 clock = ~clock;

    multiport_regfile #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b0), .CNT_W(8)) dut0 (
        .clock(clock), .clear(clear),
        .write1(write1), .write_data1(write_data1), .write_index1(write_index1),
        .write2(write2), .write_data2(write_data2), .write_index2(write_index2),
        .read_index1(read_index1), .read_value1(rv1[0]), .read_valid1(rl1[0]),
        .read_index2(read_index2), .read_value2(rv2[0]), .read_valid2(rl2[0]),
        .collision_count(cc[0])
    );

    multiport_regfile #(.WIDTH(32), .DEPTH(20), .ZERO_REG(1'b1), .CNT_W(8)) dut1 (
        .clock(clock), .clear(clear),
        .write1(write1), .write_data1(write_data1), .write_index1(write_index1),
        .write2(write2), .write_data2(write_data2), .write_index2(write_index2),
        .read_index1(read_index1), .read_value1(rv1[1]), .read_valid1(rl1[1]),
        .read_index2(read_index2), .read_value2(rv2[1]), .read_valid2(rl2[1]),
        .collision_count(cc[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit writable(input int k, input int i);
        return i < depth[k] && !(zr[k] && i == 0);
    endfunction

    function automatic logic [32:0] expect_read(input int k, input int i, input bit clr);
        if (clr) return {zr[k] && i == 0, 32'h0};
        if (i >= depth[k]) return '0;
        if (zr[k] && i == 0) return {1'b1, 32'h0};
        return {m_vld[k][i], m_mem[k][i]};
    endfunction

    task automatic step(input bit c, input bit a, input int ia, input logic [31:0] da,
                        input bit b, input int ib, input logic [31:0] db, input int ra, input int rb);
        logic [32:0] e1, e2;
        clear = c; write1 = a; write_index1 = 5'(ia); write_data1 = da;
        write2 = b; write_index2 = 5'(ib); write_data2 = db;
        read_index1 = 5'(ra); read_index2 = 5'(rb);
        @(posedge clock);
        for (int k = 0; k < 2; k++) begin
            if (c) begin
                for (int i = 0; i < 32; i++) begin
                    m_mem[k][i] = 0;
                    m_vld[k][i] = 0;
                end
                m_cnt[k] = 0;
            end else begin
                // port 2 is applied last so it wins a same-index write
                if (a && writable(k, ia)) begin m_mem[k][ia] = da; m_vld[k][ia] = 1; end
                if (b && writable(k, ib)) begin m_mem[k][ib] = db; m_vld[k][ib] = 1; end
                if (a && b && ia == ib && writable(k, ia) && m_cnt[k] < 255) m_cnt[k]++;
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            e1 = expect_read(k, ra, c);
            e2 = expect_read(k, rb, c);
            check($sformatf("d%0d_value1[%0d]", k, ra), 64'(rv1[k]), 64'(e1[31:0]));
            check($sformatf("d%0d_valid1[%0d]", k, ra), 64'(rl1[k]), 64'(e1[32]));
            check($sformatf("d%0d_value2[%0d]", k, rb), 64'(rv2[k]), 64'(e2[31:0]));
            check($sformatf("d%0d_valid2[%0d]", k, rb), 64'(rl2[k]), 64'(e2[32]));
            check($sformatf("d%0d_count", k), 64'(cc[k]), 64'(m_cnt[k]));
        end
    endtask

    initial begin
        int ia, ib;
        step(1, 0, 0, 0, 0, 0, 0, 3, 4);
        step(0, 1, 3, 255, 0, 0, 0, 3, 4);
        check("wt_value", 64'(rv1[0]), 64'd255);
        check("wt_valid", 64'(rl1[0]), 64'd1);
        check("empty_valid", 64'(rl2[0]), 64'd0);
        step(0, 1, 0, 255, 1, 0, 200, 0, 3);
        check("coll_data", 64'(rv1[0]), 64'd200);
        check("coll_one", 64'(cc[0]), 64'd1);
        for (int n = 0; n < 299; n++) step(0, 1, 0, 255, 1, 0, 200, 0, 0);
        check("coll_sat", 64'(cc[0]), 64'd255);
        check("zero_no_coll", 64'(cc[1]), 64'd0);
        step(0, 1, 5, 32'hAAAA_AAAA, 1, 6, 32'h5555_5555, 5, 6);
        check("diff_a", 64'(rv1[0]), 64'hAAAA_AAAA);
        check("diff_b", 64'(rv2[0]), 64'h5555_5555);
        check("diff_cnt", 64'(cc[0]), 64'd255);
        step(0, 1, 7, 1, 0, 0, 0, 7, 7);
        step(1, 1, 7, 9, 0, 0, 0, 7, 0);
        step(0, 0, 0, 0, 0, 0, 0, 7, 7);
        check("clr_value", 64'(rv1[0]), 64'd0);
        check("clr_valid", 64'(rl1[0]), 64'd0);
        check("clr_cnt", 64'(cc[0]), 64'd0);
        step(0, 1, 0, 123, 0, 0, 0, 0, 0);
        check("zr_value", 64'(rv1[1]), 64'd0);
        check("zr_valid", 64'(rl1[1]), 64'd1);
        check("nz_value", 64'(rv1[0]), 64'd123);
        step(0, 1, 25, 77, 1, 19, 88, 25, 19);
        check("oor_valid", 64'(rl1[1]), 64'd0);
        check("top_value", 64'(rv2[1]), 64'd88);
        check("oor_value_d0", 64'(rv1[0]), 64'd77);
        for (int n = 0; n < 3000; n++) begin
            // narrow index ranges now and then to provoke collisions and write-through hits
            ia = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(0, 31);
            ib = ($urandom_range(0, 2) == 0) ? ia : $urandom_range(0, 31);
            step($urandom_range(0, 99) == 0, 1'($urandom), ia, $urandom,
                 1'($urandom), ib, $urandom,
                 ($urandom_range(0, 2) == 0) ? ia : $urandom_range(0, 31),
                 ($urandom_range(0, 2) == 0) ? ib : $urandom_range(0, 31));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
